// File: rtl/param_seq_detector.sv
// -----------------------------------------------------------------------------
// param_seq_detector
//   Serial pattern detector for a debounced switch stream. The last PAT_LEN
//   samples (taken only when 'valid' is high) are compared against a pattern
//   register that can be reloaded at run time. Features:
//     - Mealy (combinational, same-cycle) or Moore (one-clock-late, held) detect
//       output, selectable on the fly.
//     - Overlapping or non-overlapping matching.
//     - Saturating match counter with a synchronous clear.
//     - Matched-prefix length output for an LED bar.
//
// Ports
//   clock        in   1                  system clock, rising edge
//   reset        in   1                  asynchronous, active-low reset
//   X            in   1                  serial data bit
//   valid        in   1                  X is a new sample this cycle
//   M            in   1                  0 = Moore output, 1 = Mealy output
//   O            in   1                  1 = overlapping, 0 = non-overlapping
//   pat_load     in   1                  load pat_in (wins over valid)
//   pat_in       in   PAT_LEN            new pattern, MSB is first bit received
//   clr_count    in   1                  synchronous clear of match_count
//   Z            out  1                  detect output
//   progress     out  $clog2(PAT_LEN+1)  length of the matched pattern prefix
//   match_count  out  CNT_W              number of detections, saturating
// -----------------------------------------------------------------------------
module param_seq_detector #(
    parameter int                 PAT_LEN = 6,
    parameter logic [PAT_LEN-1:0] PATTERN = 6'b010110,
    parameter int                 CNT_W   = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           X,
    input  logic                           valid,
    input  logic                           M,
    input  logic                           O,
    input  logic                           pat_load,
    input  logic [PAT_LEN-1:0]             pat_in,
    input  logic                           clr_count,
    output logic                           Z,
    output logic [$clog2(PAT_LEN+1)-1:0]   progress,
    output logic [CNT_W-1:0]               match_count
);

    localparam int FW = $clog2(PAT_LEN + 1);

    // History shift register, newest sample in bit 0.
    logic [PAT_LEN-1:0] hist_r;
    // Number of samples held since the last clear, saturating at PAT_LEN.
    logic [FW-1:0]      fill_r;
    logic [PAT_LEN-1:0] pat_r;
    logic               z_moore_r;
    logic [CNT_W-1:0]   count_r;

    logic [PAT_LEN-1:0] win_s;
    logic               hit_s;
    logic [FW-1:0]      progress_s;
    logic [PAT_LEN-1:0] mask_s;
    logic [CNT_W-1:0]   count_next_s;

    // Candidate window and the combinational hit decision for this sample.
    always_comb begin
        win_s = {hist_r[PAT_LEN-2:0], X};
        hit_s = 1'b0;
        if (valid && !pat_load && (fill_r >= FW'(PAT_LEN - 1)) && (win_s == pat_r)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
    end

    // Longest pattern prefix that ends the held history; uses registered state only.
    // A longer k that also matches overwrites a shorter one, so the loop yields the maximum.
    always_comb begin
        progress_s = '0;
        mask_s     = '0;
        for (int k = 1; k < PAT_LEN; k++) begin
            mask_s = {PAT_LEN{1'b1}} >> (PAT_LEN - k);
            if ((FW'(k) <= fill_r) &&
                ((hist_r & mask_s) == ((pat_r >> (PAT_LEN - k)) & mask_s))) begin
                progress_s = FW'(k);
            end else begin
                progress_s = progress_s;
            end
        end
    end

    // Next match count: a clear coincident with a hit leaves exactly one detection.
    always_comb begin
        count_next_s = count_r;
        if (clr_count) begin
            if (hit_s) begin
                count_next_s = CNT_W'(1);
            end else begin
                count_next_s = '0;
            end
        end else if (hit_s && (count_r != {CNT_W{1'b1}})) begin
            count_next_s = count_r + CNT_W'(1);
        end else begin
            count_next_s = count_r;
        end
    end

    // Detector state: history, fill level, pattern, Moore flop and counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hist_r    <= '0;
            fill_r    <= '0;
            pat_r     <= PATTERN;
            z_moore_r <= 1'b0;
            count_r   <= '0;
        end else begin
            if (pat_load) begin
                // A sample arriving with the load is dropped on purpose.
                pat_r     <= pat_in;
                fill_r    <= '0;
                z_moore_r <= 1'b0;
            end else if (valid) begin
                hist_r    <= win_s;
                z_moore_r <= hit_s;
                if (hit_s && !O) begin
                    fill_r <= '0;
                end else if (fill_r != FW'(PAT_LEN)) begin
                    fill_r <= fill_r + FW'(1);
                end else begin
                    fill_r <= fill_r;
                end
            end else begin
                hist_r    <= hist_r;
                fill_r    <= fill_r;
                z_moore_r <= z_moore_r;
            end
            count_r <= count_next_s;
        end
    end

    // Mealy output must be same-cycle, so Z is a mux rather than a flop.
    assign Z           = M ? hit_s : z_moore_r;
    assign progress    = progress_s;
    assign match_count = count_r;

endmodule

// File: tb/tb_param_seq_detector.sv
// Scoreboard bench for param_seq_detector. Two instances (CNT_W=8 and CNT_W=2)
// share the stimulus. The reference model keeps the samples received since the
// last clear in a bit queue and derives hits and prefix length from it.
module tb_param_seq_detector;

    localparam int L  = 6;
    localparam int PW = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic X = 1'b0, valid = 1'b0, M = 1'b0, O = 1'b0, pat_load = 1'b0, clr_count = 1'b0;
    logic [L-1:0] pat_in = '0;
    logic Z, Z2;
    logic [PW-1:0] progress, progress2;
    logic [7:0] match_count;
    logic [1:0] match_count2;

    param_seq_detector #(.PAT_LEN(L), .PATTERN(6'b010110), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .X(X), .valid(valid), .M(M), .O(O),
        .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
        .Z(Z), .progress(progress), .match_count(match_count));

    param_seq_detector #(.PAT_LEN(L), .PATTERN(6'b010110), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .X(X), .valid(valid), .M(M), .O(O),
        .pat_load(pat_load), .pat_in(pat_in), .clr_count(clr_count),
        .Z(Z2), .progress(progress2), .match_count(match_count2));

    always #5 clock = ~clock;

    typedef struct {
        bit z;
        int prog;
        int c8;
        int c2;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    // Reference model state
    bit           seen[$];
    logic [L-1:0] m_pat;
    logic [L-1:0] pat_default;
    bit           m_zm;
    int           m_c8, m_c2;
    bit           cur_m, cur_o;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp_v, $time);
        end
    endtask

    // One clock of stimulus: drive, compute model outputs, queue them, update model.
    task automatic step(input bit rst_v, input bit x_v, input bit v_v,
                        input bit load_v, input logic [L-1:0] pin, input bit clr_v);
        bit   hit;
        int   prog, lim, n;
        bit   ok;
        exp_t ex;
        @(negedge clock);
        reset = rst_v; X = x_v; valid = v_v; M = cur_m; O = cur_o;
        pat_load = load_v; pat_in = pin; clr_count = clr_v;
        #1;
        if (!rst_v) begin
            seen.delete();
            m_pat = pat_default;
            m_zm = 1'b0; m_c8 = 0; m_c2 = 0;
            ex.z = 1'b0; ex.prog = 0; ex.c8 = 0; ex.c2 = 0;
            sb.push_back(ex);
        end else begin
            n = seen.size();
            hit = 1'b0;
            if (v_v && !load_v && n >= L - 1) begin
                ok = (x_v == m_pat[0]);
                for (int i = 0; i < L - 1; i++)
                    if (seen[n - (L - 1) + i] != m_pat[L - 1 - i]) ok = 1'b0;
                hit = ok;
            end
            lim = (n < L - 1) ? n : L - 1;
            prog = 0;
            for (int k = 1; k <= lim; k++) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++)
                    if (seen[n - k + j] != m_pat[L - 1 - j]) ok = 1'b0;
                if (ok) prog = k;
            end
            ex.z = cur_m ? hit : m_zm;
            ex.prog = prog; ex.c8 = m_c8; ex.c2 = m_c2;
            sb.push_back(ex);
            // state update for the coming edge
            if (load_v) begin
                m_pat = pin; seen.delete(); m_zm = 1'b0;
            end else if (v_v) begin
                m_zm = hit;
                if (hit && !cur_o) seen.delete();
                else begin
                    seen.push_back(x_v);
                    if (seen.size() > L) void'(seen.pop_front());
                end
            end
            if (clr_v) begin
                m_c8 = hit ? 1 : 0; m_c2 = hit ? 1 : 0;
            end else if (hit) begin
                if (m_c8 < 255) m_c8++;
                if (m_c2 < 3) m_c2++;
            end
        end
    endtask

    task automatic sample(input bit x_v);
        step(1'b1, x_v, 1'b1, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic send_bits(input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) sample(bits[n - 1 - i]);
    endtask

    // Monitor: compares both instances against the queued expectation each cycle.
    always @(negedge clock) begin
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("Z", int'(Z), int'(e.z));
            check("progress", int'(progress), e.prog);
            check("match_count", int'(match_count), e.c8);
            check("Z_w2", int'(Z2), int'(e.z));
            check("progress_w2", int'(progress2), e.prog);
            check("match_count_w2", int'(match_count2), e.c2);
        end
    end

    initial begin
        logic [L-1:0] rp;
        int r;
        pat_default = 6'b010110;
        m_pat = pat_default;

        // Mealy, overlapping
        cur_m = 1'b1; cur_o = 1'b1;
        do_reset();
        check("rst_count", int'(match_count), 0);
        send_bits(16'b010110, 6);
        idle();
        check("t2_prog_after6", int'(progress), 1);
        check("t2_count_after6", int'(match_count), 1);
        send_bits(16'b10110, 5);
        idle();
        check("t2_count_end", int'(match_count), 2);

        // Mealy, non-overlapping
        cur_o = 1'b0;
        do_reset();
        send_bits(16'b010110, 6);
        idle();
        check("t3_prog_after6", int'(progress), 0);
        send_bits(16'b10110, 5);
        idle();
        check("t3_count_end", int'(match_count), 1);
        check("t3_prog_end", int'(progress), 1);

        // Moore with idle gaps
        cur_m = 1'b0; cur_o = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic [5:0] b;
            b = 6'b010110;
            sample(b[5 - i]);
            for (int g = 0; g < 3; g++) begin
                idle();
                if (i == 4 && g == 0) check("t4_z_before", int'(Z), 0);
                if (i == 5) check("t4_z_hold", int'(Z), 1);
            end
        end
        sample(1'b1);
        idle();
        check("t4_z_drop", int'(Z), 0);

        // Pattern load with a coincident sample
        cur_m = 1'b1; cur_o = 1'b1;
        do_reset();
        step(1'b1, 1'b1, 1'b1, 1'b1, 6'b111000, 1'b0);
        send_bits(16'b11100, 5);
        idle();
        check("t5_count_before", int'(match_count), 0);
        sample(1'b0);
        idle();
        check("t5_count_after", int'(match_count), 1);

        // Saturation of the narrow counter, clear with hit
        do_reset();
        send_bits(16'b010110, 6);
        for (int i = 0; i < 4; i++) send_bits(16'b10110, 5);
        idle();
        check("t6_count8", int'(match_count), 5);
        check("t6_count2_sat", int'(match_count2), 3);
        send_bits(16'b1011, 4);
        step(1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b1);
        idle();
        check("t6_clr_hit8", int'(match_count), 1);
        check("t6_clr_hit2", int'(match_count2), 1);

        // Reset mid-stream restores the default pattern
        step(1'b1, 1'b0, 1'b0, 1'b1, 6'b111000, 1'b0);
        send_bits(16'b0101, 4);
        step(1'b0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
        check("t1_rst_z", int'(Z), 0);
        check("t1_rst_prog", int'(progress), 0);
        check("t1_rst_count", int'(match_count), 0);
        send_bits(16'b010110, 6);
        idle();
        check("t1_default_pat", int'(match_count), 1);

        // Randomized phase
        for (int c = 0; c < 3000; c++) begin
            r = int'($urandom_range(0, 999));
            if (r < 2) begin
                step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
            end else if (r < 12) begin
                rp = ($urandom_range(0, 3) == 0) ? 6'b000000 : L'($urandom);
                step(1'b1, 1'($urandom), 1'($urandom), 1'b1, rp, 1'($urandom_range(0, 3) == 0));
            end else begin
                if ($urandom_range(0, 49) == 0) cur_m = 1'($urandom);
                if ($urandom_range(0, 49) == 0) cur_o = 1'($urandom);
                step(1'b1, 1'($urandom), 1'($urandom_range(0, 3) != 0), 1'b0, '0,
                     1'($urandom_range(0, 49) == 0));
            end
        end

        idle();
        idle();
        @(negedge clock);
        #5;
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
